pipelined_memory: RTL

- Behavioural byte-addressable memory model for testbenches, parametrised in address width, word width and read latency.
- Requests use a valid/ready handshake; any byte alignment is allowed; per-byte write/read enables generalise the fixed left/right half-word modes.
- On reset the memory clears itself word-by-word under a small state machine, and refuses requests until clearing is done.
- Sits between the CPU pipeline (instruction or data port) and the bench, replacing the fixed single-cycle memory model.

---
 rtl/pipelined_memory.sv | 96 +++++++++
 1 files changed

// File: rtl/pipelined_memory.sv
// Byte-addressable behavioural memory with valid/ready requests, per-lane enables,
// address wrap-around, a self-clearing INIT phase after reset and a fixed-latency read pipeline.
module pipelined_memory #(
  parameter int unsigned AddressSize = 16,
  parameter int unsigned WordSize    = 32,
  parameter int unsigned Latency     = 1,
  localparam int unsigned BytesPerWord = WordSize / 8
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [BytesPerWord-1:0] ByteEn,
  input  logic [AddressSize-1:0]  Address,
  input  logic [WordSize-1:0]     WriteData,
  output logic                    RspValid,
  output logic [WordSize-1:0]     ReadData
);

  localparam int unsigned WordAddrBits = AddressSize - $clog2(BytesPerWord);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [WordAddrBits-1:0] wc;
  logic [7:0]              mem [2**AddressSize];

  logic                    accept;
  logic [AddressSize-1:0]  lane_addr [BytesPerWord];
  logic [AddressSize-1:0]  clr_base;
  logic [WordSize-1:0]     rd_word;

  logic                    pipe_valid [Latency];
  logic [WordSize-1:0]     pipe_data  [Latency];

  assign accept   = ReqValid && ReqReady;
  assign clr_base = AddressSize'(wc) * AddressSize'(BytesPerWord);

  // Lane addresses wrap naturally by truncation to AddressSize bits.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < BytesPerWord; i++) begin
      lane_addr[i] = Address + AddressSize'(i);
      if (ByteEn[i])
        rd_word[8*i +: 8] = mem[lane_addr[i]];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= INIT;
      wc       <= '0;
      ReqReady <= 1'b0;
    end else if (state == INIT) begin
      wc <= wc + WordAddrBits'(1);
      if (wc == '1) begin
        state    <= RUN;
        ReqReady <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents become defined once INIT has swept every word.
  always_ff @(posedge Clock) begin
    if (state == INIT) begin
      for (int unsigned i = 0; i < BytesPerWord; i++)
        mem[clr_base + AddressSize'(i)] <= 8'h00;
    end else if (accept && ReqWrite) begin
      for (int unsigned i = 0; i < BytesPerWord; i++)
        if (ByteEn[i])
          mem[lane_addr[i]] <= WriteData[8*i +: 8];
    end
  end

  // Data is zeroed alongside a cleared valid so ReadData is 0 whenever RspValid is 0.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned s = 0; s < Latency; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_data[s]  <= '0;
      end
    end else begin
      pipe_valid[0] <= accept && !ReqWrite;
      pipe_data[0]  <= (accept && !ReqWrite) ? rd_word : '0;
      for (int unsigned s = 1; s < Latency; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  assign RspValid = pipe_valid[Latency-1];
  assign ReadData = pipe_data[Latency-1];

endmodule
